pipeline_wb: RTL
================

Name: pipeline_WB

Overview:
- Write-back stage and architectural register file of the 8-bit pipeline.
- Consumes the MEM/WB pipeline register outputs: DM data, ALU result, destination register and the two write-back controls.
- Selects the write-back value, commits it to a 4x8 register file, and serves the two decode-stage read ports with same-cycle write bypass.
- Keeps a commit counter and a per-register written-flag scoreboard that raises a sticky uninitialised-read flag.

Parameters:
- DATA_W, 8, datapath width.
- ADDR_W, 2, register address width; register count is 2**ADDR_W.
- CNT_W, 16, commit counter width.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- DM  input  DATA_W  load data from the MEM/WB register.
- ALU_ea  input  DATA_W  ALU result from the MEM/WB register.
- ra  input  ADDR_W  destination register.
- wb_wb_sel  input  1  1 = write DM, 0 = write ALU_ea.
- wb_reg_en  input  1  commit enable.
- rs1_addr  input  ADDR_W  read port 1 address.
- rs1_en  input  1  read port 1 in use; qualifies the scoreboard check.
- rs2_addr  input  ADDR_W  read port 2 address.
- rs2_en  input  1  read port 2 in use.
- rs1_data  output  DATA_W  read port 1 data, combinational.
- rs2_data  output  DATA_W  read port 2 data, combinational.
- wb_data  output  DATA_W  selected write-back value, combinational, for forwarding.
- commit_count  output  CNT_W  number of committed writes.
- uninit_read  output  1  sticky flag: an enabled read hit a never-written register.

Behaviour:
- wb_data = wb_wb_sel ? DM : ALU_ea. Pure mux, zero latency, valid whenever inputs are valid, independent of wb_reg_en.
- Commit on posedge clk when wb_reg_en=1 and rst=0:
  - regs[ra] <= wb_data.
  - written[ra] <= 1.
  - commit_count <= commit_count+1, wrapping modulo 2**CNT_W (0xFFFF -> 0x0000, no saturation).
- Read ports, each identical and independent:
  - If wb_reg_en=1 and rsN_addr==ra, rsN_data = wb_data (bypass).
  - Otherwise rsN_data = regs[rsN_addr].
  - Both ports may read the same register; both may bypass in the same cycle.
- Scoreboard:
  - Each cycle, for each port with rsN_en=1, the read is flagged if written[rsN_addr]=0 and the read is not bypassed.
  - Any flagged read sets uninit_read <= 1 at the next edge. The flag clears only on rst.
  - A bypassed read of a never-written register is not flagged.
  - Reads with rsN_en=0 are never flagged.
- Reset, synchronous, takes precedence over a simultaneous commit. At the edge with rst=1:
  - All regs <= 0, all written bits <= 0.
  - commit_count <= 0, uninit_read <= 0.
  - A pending commit in that cycle is discarded and not counted.
  - While rst=1, the combinational outputs still follow inputs: wb_data follows the mux and bypass still applies; reads of non-bypassed registers return their current stored values.
- No state machine; all state is the register array, the written bits, the counter and the sticky flag.
- Commits are never stalled; the stage always accepts.

Decomposition:
- Shared pipeline package holds:
  - DATA_W and ADDR_W constants.
  - Write-back select encoding: WB_SEL_ALU=0, WB_SEL_DM=1.
  - Register-address typedef.
- One natural sub-module, pipeline_regfile: the array plus written bits with one write port and two bypassed read ports.
- The top level holds the mux, the counter and the sticky flag.

Test Plan:
- Reset, then read all 4 registers with rsN_en=0 -> all 0x00, commit_count=0, uninit_read=0.
- ALU_ea=0x3C, wb_wb_sel=0, ra=2, wb_reg_en=1 for one cycle; then rs1_addr=2 -> rs1_data=0x3C, commit_count=1. With DM=0xA5, wb_wb_sel=1, ra=1 -> rs2 reads 0xA5, count=2.
- Same-cycle bypass: commit 0x77 to r3 while rs1_addr=rs2_addr=3 and rs1_en=1 -> both ports show 0x77 that cycle; uninit_read stays 0; rs1 still reads 0x77 the next cycle.
- After reset, rs2_en=1, rs2_addr=0 with no write to r0 -> uninit_read=1 after the edge. It stays 1 through later writes to r0 and clears only after rst.
- 65536 consecutive commits from reset -> commit_count wraps to 0x0000. wb_reg_en=0 cycles leave the count and registers unchanged.
- rst=1 in the same cycle as a commit of 0x55 to r1 -> after the edge r1=0x00, commit_count=0, written[1]=0. A subsequent enabled read of r1 sets uninit_read.

Source files
------------

// File: rtl/pipeline_wb_pkg.sv
// Shared constants and types for the 8-bit pipeline write-back stage.
package pipeline_wb_pkg;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 2;
    localparam int CNT_W  = 16;

    typedef enum logic {
        WB_SEL_ALU = 1'b0,
        WB_SEL_DM  = 1'b1
    } wb_sel_e;

    typedef logic [ADDR_W-1:0] reg_addr_t;

endpackage

// File: rtl/pipeline_wb_regfile.sv
// Architectural register file: one write port, two read ports with same-cycle
// write bypass, and a written bit per register for the uninitialised-read scoreboard.
module pipeline_wb_regfile #(
    parameter int DATA_W = pipeline_wb_pkg::DATA_W,
    parameter int ADDR_W = pipeline_wb_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] wa,
    input  logic [DATA_W-1:0] wd,
    input  logic [ADDR_W-1:0] ra1,
    input  logic [ADDR_W-1:0] ra2,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2,
    output logic              byp1,
    output logic              byp2,
    output logic              written1,
    output logic              written2
);
    import pipeline_wb_pkg::*;

    localparam int NREGS = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs_r [NREGS];
    logic [NREGS-1:0]  written_r;

    // Register array and written bits; reset wins over a same-cycle write.
    always_ff @(posedge clk) begin
        if (rst) begin
            regs_r    <= '{default: '0};
            written_r <= '0;
        end else if (we) begin
            regs_r[wa]    <= wd;
            written_r[wa] <= 1'b1;
        end
    end

    // Read ports: a write to the same address this cycle is forwarded directly.
    always_comb begin
        byp1     = we && (ra1 == wa);
        byp2     = we && (ra2 == wa);
        written1 = written_r[ra1];
        written2 = written_r[ra2];
        if (byp1) begin
            rd1 = wd;
        end else begin
            rd1 = regs_r[ra1];
        end
        if (byp2) begin
            rd2 = wd;
        end else begin
            rd2 = regs_r[ra2];
        end
    end

endmodule

// File: rtl/pipeline_wb.sv
// Write-back stage: selects the commit value, writes the register file, counts
// commits and raises a sticky flag when an enabled read hits a never-written register.
module pipeline_wb #(
    parameter int DATA_W = pipeline_wb_pkg::DATA_W,
    parameter int ADDR_W = pipeline_wb_pkg::ADDR_W,
    parameter int CNT_W  = pipeline_wb_pkg::CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] DM,
    input  logic [DATA_W-1:0] ALU_ea,
    input  logic [ADDR_W-1:0] ra,
    input  logic              wb_wb_sel,
    input  logic              wb_reg_en,
    input  logic [ADDR_W-1:0] rs1_addr,
    input  logic              rs1_en,
    input  logic [ADDR_W-1:0] rs2_addr,
    input  logic              rs2_en,
    output logic [DATA_W-1:0] rs1_data,
    output logic [DATA_W-1:0] rs2_data,
    output logic [DATA_W-1:0] wb_data,
    output logic [CNT_W-1:0]  commit_count,
    output logic              uninit_read
);
    import pipeline_wb_pkg::*;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic              byp1_s;
    logic              byp2_s;
    logic              written1_s;
    logic              written2_s;
    logic              flag_s;
    logic [CNT_W-1:0]  commit_count_r;
    logic              uninit_read_r;

    // Write-back source select and uninitialised-read detection.
    always_comb begin
        if (wb_wb_sel == WB_SEL_DM) begin
            wb_data = DM;
        end else begin
            wb_data = ALU_ea;
        end
        flag_s = (rs1_en && !written1_s && !byp1_s) ||
                 (rs2_en && !written2_s && !byp2_s);
    end

    pipeline_wb_regfile #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_regfile (
        .clk      (clk),
        .rst      (rst),
        .we       (wb_reg_en),
        .wa       (ra),
        .wd       (wb_data),
        .ra1      (rs1_addr),
        .ra2      (rs2_addr),
        .rd1      (rs1_data),
        .rd2      (rs2_data),
        .byp1     (byp1_s),
        .byp2     (byp2_s),
        .written1 (written1_s),
        .written2 (written2_s)
    );

    // Commit counter wraps naturally; the uninit flag is sticky until reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            commit_count_r <= '0;
            uninit_read_r  <= 1'b0;
        end else begin
            if (wb_reg_en) begin
                commit_count_r <= commit_count_r + CNT_ONE;
            end
            if (flag_s) begin
                uninit_read_r <= 1'b1;
            end
        end
    end

    assign commit_count = commit_count_r;
    assign uninit_read  = uninit_read_r;

endmodule
